// File: rtl/sll_iter_pkg.sv
// Shared types and helpers for the iterative left shifter.
package sll_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of shift-amount bits (and stage iterations) for an N-bit operand.
  function automatic int calc_k(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer.
module mux2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/sll_stage.sv
// One iteration of the shifter: shift by 2^s when amount bit s is set.
module sll_stage #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic [N-1:0] data_i,
  input  logic [K-1:0] amt_i,
  input  logic [K-1:0] s_i,
  output logic [N-1:0] data_o
);

  logic [N-1:0] shifted [K];
  logic [N-1:0] shift_sel;
  logic         amt_bit;

  for (genvar k = 0; k < K; k++) begin : g_const_shift
    assign shifted[k] = data_i << (1 << k);
  end

  // Explicit decode keeps index widths exact for any K.
  always_comb begin
    shift_sel = '0;
    amt_bit   = 1'b0;
    for (int k = 0; k < K; k++) begin
      if (s_i == K'(k)) begin
        shift_sel = shifted[k];
        amt_bit   = amt_i[k];
      end
    end
  end

  mux2 #(.W(N)) u_mux (
    .a_i  (data_i),
    .b_i  (shift_sel),
    .sel_i(amt_bit),
    .y_o  (data_o)
  );

endmodule

// File: rtl/sll_iter.sv
// Iterative logical left shifter: one shift-amount bit resolved per clock,
// fixed latency of K+1 cycles from start to done.
module sll_iter
  import sll_iter_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [$clog2(N)-1:0]  shift_amount,
  input  logic [N-1:0]          dataIn,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          dataOut
);

  localparam int K = calc_k(N);
  localparam logic [K-1:0] S_LAST = K'(K - 1);

  state_e       state_q, state_d;
  logic [K-1:0] s_q, s_d;
  logic [K-1:0] amt_q, amt_d;
  logic [N-1:0] work_q, work_d;
  logic [N-1:0] stage_out;

  sll_stage #(.N(N), .K(K)) u_stage (
    .data_i(work_q),
    .amt_i (amt_q),
    .s_i   (s_q),
    .data_o(stage_out)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    amt_d   = amt_q;
    work_d  = work_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          work_d  = dataIn;
          amt_d   = shift_amount;
          s_d     = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        if (s_q == S_LAST) begin
          state_d = DONE;
        end else begin
          s_d = s_q + K'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      amt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      amt_q   <= amt_d;
      work_q  <= work_d;
    end
  end

  // Outputs decode straight from flops; no input-to-output paths.
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign dataOut = work_q;

endmodule

// File: tb/tb_sll_iter.sv
// Directed and swept checks of sll_iter at N=16 (K=4).
module tb_sll_iter;

  localparam int N = 16;
  localparam int K = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [K-1:0] shift_amount;
  logic [N-1:0] dataIn;
  logic         busy;
  logic         done;
  logic [N-1:0] dataOut;

  int n_checks = 0;
  int n_pass   = 0;

  sll_iter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .shift_amount(shift_amount),
    .dataIn      (dataIn),
    .busy        (busy),
    .done        (done),
    .dataOut     (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Issue start in the current cycle c (called just after a negedge), then
  // check busy for c+1..c+K, done and the result at c+K+1.
  task automatic run_op(input string tag, input logic [N-1:0] d, input logic [K-1:0] a,
                        input logic [N-1:0] exp);
    start = 1'b1; dataIn = d; shift_amount = a;
    for (int i = 1; i <= K + 1; i++) begin
      @(negedge clk);
      start = 1'b0;
      dataIn = ~d; shift_amount = ~a;
      chk({tag, "_busy"}, busy, (i <= K));
      chk({tag, "_done"}, done, (i == K + 1));
    end
    chk({tag, "_data"}, dataOut, exp);
  endtask

  task automatic run_sweep(input logic [N-1:0] d, input logic [K-1:0] a);
    int lat;
    logic [N-1:0] exp;
    exp = d << a;
    start = 1'b1; dataIn = d; shift_amount = a;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 12);
    chk("sweep_lat", lat, K + 1);
    chk("sweep_data", dataOut, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; shift_amount = '0; dataIn = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", dataOut, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("amt15", 16'h0001, 4'd15, 16'h8000);
    @(negedge clk);
    chk("idle_done", done, 0);
    run_op("abcd4", 16'hABCD, 4'd4, 16'hBCD0);
    run_op("ffff8", 16'hFFFF, 4'd8, 16'hFF00);
    run_op("amt0", 16'h1234, 4'd0, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold", dataOut, 16'h1234);
    end

    // Start ignored while busy, then back-to-back start in the done cycle.
    start = 1'b1; dataIn = 16'h00F0; shift_amount = 4'd1;
    @(negedge clk);                                   // c+1
    start = 1'b0;
    @(negedge clk);                                   // c+2
    start = 1'b1; dataIn = 16'h0F0F; shift_amount = 4'd3;
    @(negedge clk);                                   // c+3
    start = 1'b0;
    chk("ign_busy3", busy, 1);
    @(negedge clk);                                   // c+4
    chk("ign_busy4", busy, 1);
    @(negedge clk);                                   // c+5
    chk("ign_done", done, 1);
    chk("ign_data", dataOut, 16'h01E0);
    run_op("b2b", 16'h0003, 4'd2, 16'h000C);          // done at c+10

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start = 1'b1; dataIn = 16'hABCD; shift_amount = 4'd4;
    @(negedge clk);                                   // c+1
    start = 1'b0;
    @(negedge clk);                                   // c+2
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_data", dataOut, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("arst_nodone", seen, 0);
    end
    run_op("post_rst", 16'h0001, 4'd1, 16'h0002);

    for (int i = 0; i < 1000; i++) begin
      run_sweep(N'($urandom), K'($urandom_range(0, N - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
